// File: rtl/ratio_sine_pkg.sv
// Shared widths and divider state encoding for the ratio/sine arithmetic datapath.
package ratio_sine_pkg;

  localparam int DIVIDEND_W = 26;
  localparam int DIVISOR_W  = 14;
  localparam int QUOT_W     = 26;
  localparam int ANGLE_W    = 10;
  localparam int SIN_W      = 13;
  localparam int PROD_W     = 39;
  localparam int DIV_ITER   = 26;

  localparam int ITER_CNT_W = $clog2(DIV_ITER);
  localparam int S2P_CNT_W  = $clog2(ANGLE_W);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/seq_div_core.sv
// Restoring radix-2 unsigned divider: 26-bit dividend / 14-bit divisor, one quotient bit per cycle.
module seq_div_core
  import ratio_sine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  divider_ok,
  output div_state_e            state_dbg
);

  div_state_e             state;
  div_state_e             next_state;
  logic [DIVIDEND_W-1:0]  dvd_sr;
  logic [DIVISOR_W-1:0]   dvs_r;
  logic [DIVISOR_W-1:0]   rem_r;
  logic [DIVISOR_W-1:0]   rem_next;
  logic [DIVISOR_W:0]     trial;
  logic [QUOT_W-1:0]      q_sr;
  logic [QUOT_W-1:0]      q_next;
  logic [ITER_CNT_W-1:0]  iter_cnt;
  logic                   take;
  logic                   last_iter;

  // A zero divisor makes every trial succeed, so the quotient naturally fills with ones.
  always_comb begin
    trial     = {rem_r, dvd_sr[DIVIDEND_W-1]};
    take      = (trial >= {1'b0, dvs_r});
    rem_next  = take ? DIVISOR_W'(trial - {1'b0, dvs_r}) : trial[DIVISOR_W-1:0];
    q_next    = {q_sr[QUOT_W-2:0], take};
    last_iter = (iter_cnt == ITER_CNT_W'(DIV_ITER - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = BUSY;
      BUSY:    if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sr     <= '0;
      dvs_r      <= '0;
      rem_r      <= '0;
      q_sr       <= '0;
      iter_cnt   <= '0;
      quotient   <= '0;
      divider_ok <= 1'b0;
    end else begin
      divider_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            dvd_sr   <= dividend;
            dvs_r    <= divisor;
            rem_r    <= '0;
            q_sr     <= '0;
            iter_cnt <= '0;
          end
        end
        BUSY: begin
          dvd_sr   <= {dvd_sr[DIVIDEND_W-2:0], 1'b0};
          rem_r    <= rem_next;
          q_sr     <= q_next;
          iter_cnt <= iter_cnt + ITER_CNT_W'(1);
          if (last_iter) begin
            quotient   <= q_next;
            divider_ok <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ratio_sine_datapath.sv
// Ratio/sine arithmetic datapath: sequential divider, 10-bit serial-to-parallel angle, ratio x sine multiplier.
// Build option: define DIVMUL_MUL_PIPE_EN to add one register stage to the multiplier.
module ratio_sine_datapath
  import ratio_sine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  dext,
  input  logic [SIN_W-1:0]      multi2,
  output logic [ANGLE_W-1:0]    dout,
  output logic                  dout_valid,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  divider_ok,
  output logic [PROD_W-1:0]     product,
  output logic                  product_valid
);

  // Strobes (dout_valid, divider_ok) are single-cycle, with no back-pressure: the consumer
  // must take the data in the cycle the strobe is high. product_valid is a level, not a strobe.

  div_state_e div_state_unused;

  seq_div_core u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .divider_ok (divider_ok),
    .state_dbg  (div_state_unused)
  );

  logic [ANGLE_W-1:0]   s2p_sr;
  logic [S2P_CNT_W-1:0] s2p_cnt;

  // The word is emitted with the current bit folded in, so it is ready one cycle after the 10th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2p_sr     <= '0;
      s2p_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (en) begin
        s2p_sr <= {s2p_sr[ANGLE_W-2:0], dext};
        if (s2p_cnt == S2P_CNT_W'(ANGLE_W - 1)) begin
          s2p_cnt    <= '0;
          dout       <= {s2p_sr[ANGLE_W-2:0], dext};
          dout_valid <= 1'b1;
        end else begin
          s2p_cnt <= s2p_cnt + S2P_CNT_W'(1);
        end
      end
    end
  end

  logic              mul_en;
  logic [PROD_W-1:0] mul_full;

  assign mul_full = PROD_W'(quotient) * PROD_W'(multi2);

  // Sticky: once a real quotient exists the product keeps tracking it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_en <= 1'b0;
    end else if (divider_ok) begin
      mul_en <= 1'b1;
    end
  end

`ifdef DIVMUL_MUL_PIPE_EN
  logic [PROD_W-1:0] prod_s1;
  logic              prod_s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_s1       <= '0;
      prod_s1_valid <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      prod_s1_valid <= mul_en;
      product_valid <= prod_s1_valid;
      if (mul_en) begin
        prod_s1 <= mul_full;
      end
      if (prod_s1_valid) begin
        product <= prod_s1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      product_valid <= mul_en;
      if (mul_en) begin
        product <= mul_full;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ratio_sine_datapath.sv
// Directed bench for ratio_sine_datapath: divider latency/period/edge cases, multiplier, s2p, reset.
module tb_ratio_sine_datapath;
  import ratio_sine_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  dext;
  logic [SIN_W-1:0]      multi2;
  logic [ANGLE_W-1:0]    dout;
  logic                  dout_valid;
  logic [QUOT_W-1:0]     quotient;
  logic                  divider_ok;
  logic [PROD_W-1:0]     product;
  logic                  product_valid;

  ratio_sine_datapath dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .dividend      (dividend),
    .divisor       (divisor),
    .dext          (dext),
    .multi2        (multi2),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .quotient      (quotient),
    .divider_ok    (divider_ok),
    .product       (product),
    .product_valid (product_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  logic [QUOT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Bounded wait for the divider strobe; returns the number of falling edges consumed.
  task automatic wait_ok(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (divider_ok !== 1'b1 && cyc < 60);
  endtask

  task automatic check_quot(input string tag);
    logic [QUOT_W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk(tag, quotient, e);
  endtask

  initial begin
    int cyc;
    int pulses;
    int strobes;
    logic [ANGLE_W-1:0] pat;

    rst_n = 1'b0; en = 1'b0; dext = 1'b0;
    dividend = '0; divisor = '0; multi2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_divider_ok", divider_ok, 0);
    chk("rst_product", product, 0);
    chk("rst_product_valid", product_valid, 0);

    // normal divide 16384000 / 3000
    rst_n = 1'b1; en = 1'b1;
    dividend = 26'd16384000; divisor = 14'd3000; multi2 = 13'd4096;
    exp_q.push_back(26'd5461);
    wait_ok(cyc);
    chk("div_latency", cyc, 27);
    check_quot("div_quot_5461");
    chk("pv_before_mul", product_valid, 0);

    // operands change while the second division is running
    @(negedge clk);
    dividend = 26'd12345; divisor = 14'd0;
    exp_q.push_back(26'd5461);
    exp_q.push_back(26'h3FFFFFF);
    chk("ok_single_cycle", divider_ok, 0);
    chk("pv_not_yet", product_valid, 0);
    @(negedge clk);
    chk("pv_rise", product_valid, 1);
    chk("product_5461x4096", product, 64'd22368256);
    wait_ok(cyc);
    chk("div_period", cyc, 25);
    check_quot("quot_operands_ignored");

    // divide by zero, with en dropped right after capture
    @(negedge clk);
    en = 1'b0;
    wait_ok(cyc);
    chk("div0_latency", cyc, 26);
    check_quot("div0_quot");
    @(negedge clk);
    chk("product_div0", product, 64'd274877902848);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (divider_ok) pulses++;
    end
    chk("no_div_en_low", pulses, 0);

    // extreme operands
    dividend = 26'h3FFFFFF; divisor = 14'd1; multi2 = 13'h1FFF; en = 1'b1;
    exp_q.push_back(26'h3FFFFFF);
    @(negedge clk);
    en = 1'b0;
    wait_ok(cyc);
    chk("ext_latency", cyc, 26);
    check_quot("ext_quot");
    @(negedge clk);
    chk("product_extreme", product, 64'd549688696833);

    // reset in the middle of a division
    dividend = 26'd16384000; divisor = 14'd3000; multi2 = 13'd4096; en = 1'b1;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_quotient", quotient, 0);
    chk("midrst_divider_ok", divider_ok, 0);
    chk("midrst_product", product, 0);
    chk("midrst_product_valid", product_valid, 0);
    chk("midrst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(26'd5461);
    wait_ok(cyc);
    chk("post_rst_latency", cyc, 27);
    check_quot("post_rst_quot");
    chk("post_rst_pv", product_valid, 0);

    // s2p: clean word
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    pat = 10'b1011001110;
    strobes = 0;
    for (int i = 0; i < ANGLE_W; i++) begin
      dext = pat[ANGLE_W-1-i];
      @(negedge clk);
      if (i < ANGLE_W - 1 && dout_valid) strobes++;
    end
    chk("s2p_strobe", dout_valid, 1);
    chk("s2p_word", dout, 10'h2CE);

    // s2p: second word with a 3-cycle enable gap
    pat = 10'h1A5;
    cyc = 0;
    for (int i = 0; i < ANGLE_W; i++) begin
      if (i == 5) begin
        en = 1'b0;
        repeat (3) begin
          dext = ~dext;
          @(negedge clk);
          cyc++;
          if (dout_valid) strobes++;
        end
        en = 1'b1;
      end
      dext = pat[ANGLE_W-1-i];
      @(negedge clk);
      cyc++;
      if (i < ANGLE_W - 1 && dout_valid) strobes++;
    end
    chk("s2p_no_extra_strobe", strobes, 0);
    chk("s2p_stall_delay", cyc, 13);
    chk("s2p_stall_strobe", dout_valid, 1);
    chk("s2p_stall_word", dout, 10'h1A5);
    dext = 1'b0;
    @(negedge clk);
    chk("s2p_strobe_ends", dout_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
